// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rename tags at the tail, accepts results by tag,
// retires done entries from the head one per cycle as a registered commit broadcast.
module reorder_buffer #(
    parameter int ROB_BITS       = 4,
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_rd,
    output logic                      alloc_ready,
    output logic [ROB_BITS-1:0]       alloc_tag,
    input  logic                      wb_valid,
    input  logic [ROB_BITS-1:0]       wb_tag,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [ROB_BITS-1:0]       q1_tag,
    input  logic [ROB_BITS-1:0]       q2_tag,
    output logic                      q1_ready,
    output logic                      q2_ready,
    output logic [XLEN-1:0]           q1_data,
    output logic [XLEN-1:0]           q2_data,
    output logic                      commit_valid,
    output logic [REG_ADDR_WIDTH-1:0] commit_rd,
    output logic [ROB_BITS-1:0]       commit_tag,
    output logic [XLEN-1:0]           commit_data,
    input  logic                      flush,
    output logic [ROB_BITS:0]         count,
    output logic                      empty
);

    localparam int DEPTH = 1 << ROB_BITS;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [ROB_BITS:0]         head_q, head_d;
    logic [ROB_BITS:0]         tail_q, tail_d;
    logic [DEPTH-1:0]          valid_q;
    logic [DEPTH-1:0]          done_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]           data_q [DEPTH];

    logic                      commit_valid_q;
    logic [REG_ADDR_WIDTH-1:0] commit_rd_q;
    logic [ROB_BITS-1:0]       commit_tag_q;
    logic [XLEN-1:0]           commit_data_q;

    logic [ROB_BITS-1:0] head_idx;
    logic [ROB_BITS-1:0] tail_idx;
    logic                full;
    logic                alloc_fire;
    logic                retire;
    logic                wb_accept;

    assign head_idx   = head_q[ROB_BITS-1:0];
    assign tail_idx   = tail_q[ROB_BITS-1:0];
    assign full       = (head_idx == tail_idx) && (head_q[ROB_BITS] != tail_q[ROB_BITS]);
    assign alloc_fire = alloc_valid && !full;
    assign retire     = valid_q[head_idx] && done_q[head_idx];
    assign wb_accept  = wb_valid && valid_q[wb_tag] && !done_q[wb_tag];

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign count       = tail_q - head_q;
    assign empty       = (head_q == tail_q);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + {{ROB_BITS{1'b0}}, retire};
            tail_d = tail_q + {{ROB_BITS{1'b0}}, alloc_fire};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Retire, writeback and allocate never target the same entry in one cycle:
    // retire needs done, writeback needs !done, and the tail entry is free unless full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (retire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
            end
            if (wb_accept) begin
                done_q[wb_tag] <= 1'b1;
                data_q[wb_tag] <= wb_data;
            end
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                rd_q[tail_idx]    <= alloc_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_tag_q   <= '0;
            commit_data_q  <= '0;
        end else begin
            commit_valid_q <= retire && !flush;
            if (retire && !flush) begin
                commit_rd_q   <= rd_q[head_idx];
                commit_tag_q  <= head_idx;
                commit_data_q <= data_q[head_idx];
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_tag   = commit_tag_q;
    assign commit_data  = commit_data_q;

    // Query ports: a same-cycle writeback to a pending entry is forwarded.
    logic [ROB_BITS-1:0] q_tag   [2];
    logic                q_fwd   [2];
    logic                q_rdy   [2];
    logic [XLEN-1:0]     q_val   [2];

    assign q_tag[0] = q1_tag;
    assign q_tag[1] = q2_tag;

    for (genvar gi = 0; gi < 2; gi++) begin : g_query
        assign q_fwd[gi] = wb_valid && (wb_tag == q_tag[gi]) &&
                           valid_q[q_tag[gi]] && !done_q[q_tag[gi]];
        assign q_rdy[gi] = valid_q[q_tag[gi]] && (done_q[q_tag[gi]] || q_fwd[gi]);
        assign q_val[gi] = q_fwd[gi] ? wb_data : data_q[q_tag[gi]];
    end

    assign q1_ready = q_rdy[0];
    assign q2_ready = q_rdy[1];
    assign q1_data  = q_val[0];
    assign q2_data  = q_val[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner sequences and
// randomized traffic against a queue-based program-order model.
module tb_reorder_buffer;

    localparam int RB    = 4;
    localparam int XL    = 32;
    localparam int RA    = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic [RA-1:0] alloc_rd;
    logic          alloc_ready;
    logic [RB-1:0] alloc_tag;
    logic          wb_valid;
    logic [RB-1:0] wb_tag;
    logic [XL-1:0] wb_data;
    logic [RB-1:0] q1_tag, q2_tag;
    logic          q1_ready, q2_ready;
    logic [XL-1:0] q1_data, q2_data;
    logic          commit_valid;
    logic [RA-1:0] commit_rd;
    logic [RB-1:0] commit_tag;
    logic [XL-1:0] commit_data;
    logic          flush;
    logic [RB:0]   count;
    logic          empty;

    reorder_buffer #(.ROB_BITS(RB), .XLEN(XL), .REG_ADDR_WIDTH(RA)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_data(commit_data),
        .flush(flush), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: program order is a queue of tags; per-tag state in arrays.
    bit            m_valid [DEPTH];
    bit            m_done  [DEPTH];
    logic [RA-1:0] m_rd    [DEPTH];
    logic [XL-1:0] m_data  [DEPTH];
    int            order[$];
    int            m_next;
    bit            e_cv;
    int            e_crd, e_ctag;
    logic [XL-1:0] e_cdata;
    int            seen[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
        end
        order.delete();
        m_next = 0;
        e_cv   = 0;
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_rd = '0;
        wb_valid = 0; wb_tag = '0; wb_data = '0;
        q1_tag = '0; q2_tag = '0; flush = 0;
    endtask

    function automatic void q_exp(input int tag, output bit rdy, output logic [XL-1:0] d);
        bit fwd;
        fwd = wb_valid && (int'(wb_tag) == tag) && m_valid[tag] && !m_done[tag];
        rdy = m_valid[tag] && (m_done[tag] || fwd);
        d   = m_done[tag] ? m_data[tag] : wb_data;
    endfunction

    // Observe on the falling edge: combinational outputs for the current inputs
    // and the commit registers loaded on the previous rising edge.
    task automatic sample();
        bit            rdy;
        logic [XL-1:0] d;
        @(negedge clk);
        chk("alloc_ready", alloc_ready, order.size() != DEPTH);
        chk("alloc_tag", alloc_tag, m_next);
        chk("count", count, order.size());
        chk("empty", empty, order.size() == 0);
        chk("commit_valid", commit_valid, e_cv);
        if (e_cv) begin
            chk("commit_rd", commit_rd, e_crd);
            chk("commit_tag", commit_tag, e_ctag);
            chk("commit_data", commit_data, e_cdata);
        end
        if (commit_valid === 1'b1) seen.push_back(int'(commit_tag));
        q_exp(int'(q1_tag), rdy, d);
        chk("q1_ready", q1_ready, rdy);
        if (rdy) chk("q1_data", q1_data, d);
        q_exp(int'(q2_tag), rdy, d);
        chk("q2_ready", q2_ready, rdy);
        if (rdy) chk("q2_data", q2_data, d);
    endtask

    // Apply the spec rules for the coming rising edge, then let the edge happen.
    task automatic advance();
        bit ret, fire;
        int t;
        ret  = (order.size() > 0) && m_done[order[0]];
        fire = alloc_valid && (order.size() != DEPTH);
        if (flush) begin
            model_reset();
        end else begin
            e_cv = ret;
            if (ret) begin
                t = order.pop_front();
                e_crd = m_rd[t]; e_ctag = t; e_cdata = m_data[t];
                m_valid[t] = 0; m_done[t] = 0;
            end
            if (wb_valid && m_valid[wb_tag] && !m_done[wb_tag]) begin
                m_done[wb_tag] = 1;
                m_data[wb_tag] = wb_data;
            end
            if (fire) begin
                m_valid[m_next] = 1; m_done[m_next] = 0; m_rd[m_next] = alloc_rd;
                order.push_back(m_next);
                m_next = (m_next + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    // Asserted away from any edge so the asynchronous path is what clears state.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit            av;
        logic [RA-1:0] ard;
        bit            wv;
        logic [RB-1:0] wtag;
        logic [XL-1:0] wdata;
        int            cnt;
        bit            cv;
        logic [RA-1:0] crd;
        logic [RB-1:0] ctag;
        logic [XL-1:0] cdata;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued, t, idx;
        idle_inputs();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;

        // In-order commit with out-of-order writeback.
        tbl[0] = '{1, 5, 0, 0, 0,        0, 0, 0, 0, 0};
        tbl[1] = '{1, 6, 0, 0, 0,        1, 0, 0, 0, 0};
        tbl[2] = '{1, 7, 0, 0, 0,        2, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 2, 32'hA2,   3, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 1, 0, 32'hA0,   3, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 32'hA1,   3, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0,        2, 1, 5, 0, 32'hA0};
        tbl[7] = '{0, 0, 0, 0, 0,        1, 1, 6, 1, 32'hA1};
        tbl[8] = '{0, 0, 0, 0, 0,        0, 1, 7, 2, 32'hA2};
        tbl[9] = '{0, 0, 0, 0, 0,        0, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            alloc_valid = tbl[i].av; alloc_rd = tbl[i].ard;
            wb_valid = tbl[i].wv; wb_tag = tbl[i].wtag; wb_data = tbl[i].wdata;
            sample();
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_commit_valid", commit_valid, tbl[i].cv);
            if (tbl[i].cv) begin
                chk("tbl_commit_rd", commit_rd, tbl[i].crd);
                chk("tbl_commit_tag", commit_tag, tbl[i].ctag);
                chk("tbl_commit_data", commit_data, tbl[i].cdata);
            end
            advance();
        end
        idle_inputs();

        // Fill to full; overflow and commit-cycle allocations are refused.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1; alloc_rd = RA'(i + 1);
            step();
        end
        alloc_valid = 1; alloc_rd = 5'd30;
        sample();
        chk("full_count", count, 16);
        chk("full_ready", alloc_ready, 0);
        advance();
        alloc_valid = 0;
        wb_valid = 1; wb_tag = 0; wb_data = 32'hF00D;
        step();
        wb_valid = 0;
        alloc_valid = 1;
        sample();
        chk("retire_cycle_ready", alloc_ready, 0);
        advance();
        alloc_valid = 0;
        sample();
        chk("after_retire_count", count, 15);
        chk("after_retire_ready", alloc_ready, 1);
        chk("after_retire_tag", alloc_tag, 0);
        advance();

        // Streaming with up to 4 in flight; commit tags must wrap without gaps.
        do_reset();
        issued = 0;
        seen.delete();
        for (int cyc = 0; cyc < 400 && seen.size() < 40; cyc++) begin
            alloc_valid = (issued < 40) && (order.size() < 4);
            alloc_rd = RA'(issued % 32);
            wb_valid = 0;
            foreach (order[k]) begin
                if (!wb_valid && !m_done[order[k]]) begin
                    wb_valid = 1; wb_tag = RB'(order[k]); wb_data = $urandom;
                end
            end
            if (alloc_valid && order.size() != DEPTH) issued++;
            step();
        end
        chk("stream_commits", seen.size(), 40);
        for (int i = 0; i < seen.size() && i < 40; i++) chk("stream_tag", seen[i], i % 16);
        idle_inputs();

        // Writeback to a free tag, same-cycle query forward, duplicate writeback.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_rd = RA'(10 + i);
            step();
        end
        alloc_valid = 0;
        wb_valid = 1; wb_tag = 9; wb_data = 32'hDEAD;
        step();
        wb_tag = 3; wb_data = 32'h3333; q1_tag = 3;
        sample();
        chk("fwd_q1_ready", q1_ready, 1);
        chk("fwd_q1_data", q1_data, 32'h3333);
        advance();
        wb_data = 32'hBAD;
        step();
        wb_valid = 0;
        sample();
        chk("unalloc_wb_count", count, 4);
        chk("dup_wb_q1_data", q1_data, 32'h3333);
        advance();

        // Flush beats a same-cycle alloc, writeback and pending retire.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1; alloc_rd = RA'(20 + i);
            step();
        end
        alloc_valid = 0;
        wb_valid = 1; wb_tag = 1; wb_data = 32'h1111;
        step();
        wb_tag = 0; wb_data = 32'h0;
        flush = 1; alloc_valid = 1; alloc_rd = 5'd9;
        step();
        idle_inputs();
        sample();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_commit_valid", commit_valid, 0);
        chk("flush_alloc_tag", alloc_tag, 0);
        advance();

        // Randomized traffic against the model, then an asynchronous reset mid-run.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle_inputs();
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_rd = RA'($urandom);
            if (order.size() > 0 && $urandom_range(0, 9) < 7) begin
                idx = $urandom_range(0, order.size() - 1);
                t = order[idx];
                if (!m_done[t]) begin
                    wb_valid = 1; wb_tag = RB'(t); wb_data = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                t = $urandom_range(0, DEPTH - 1);
                if (!(m_valid[t] && m_done[t])) begin
                    wb_valid = 1; wb_tag = RB'(t); wb_data = $urandom;
                end
            end
            q1_tag = (wb_valid && $urandom_range(0, 1) == 1) ? wb_tag : RB'($urandom);
            q2_tag = RB'($urandom);
            flush = ($urandom_range(0, 63) == 0);
            step();
        end
        idle_inputs();
        do_reset();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
